// File: rtl/axi_2_lint_slave.sv
// rtl/axi_2_lint_slave.sv - AXI4 slave turning 32-bit read/write bursts into single-word LINT requests
module axi_2_lint_slave #(
  parameter int ADDR_WIDTH   = 32,
  parameter int AXI_ID_WIDTH = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [AXI_ID_WIDTH-1:0] aw_id_i,
  input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic [7:0]              aw_len_i,
  input  logic [2:0]              aw_size_i,
  input  logic [1:0]              aw_burst_i,
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic [31:0]             w_data_i,
  input  logic [3:0]              w_strb_i,
  input  logic                    w_last_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  output logic [AXI_ID_WIDTH-1:0] b_id_o,
  output logic [1:0]              b_resp_o,
  output logic                    b_valid_o,
  input  logic                    b_ready_i,
  input  logic [AXI_ID_WIDTH-1:0] ar_id_i,
  input  logic [ADDR_WIDTH-1:0]   ar_addr_i,
  input  logic [7:0]              ar_len_i,
  input  logic [2:0]              ar_size_i,
  input  logic [1:0]              ar_burst_i,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  output logic [AXI_ID_WIDTH-1:0] r_id_o,
  output logic [31:0]             r_data_o,
  output logic [1:0]              r_resp_o,
  output logic                    r_last_o,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic                    data_req_o,
  output logic [ADDR_WIDTH-1:0]   data_addr_o,
  output logic                    data_we_o,
  output logic [31:0]             data_wdata_o,
  output logic [3:0]              data_be_o,
  input  logic                    data_gnt_i,
  input  logic                    data_rvalid_i,
  input  logic [31:0]             data_rdata_i,
  input  logic                    data_ropc_i
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_DATA, WR_REQ, WR_WAIT, WR_RESP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_e                  state_q, state_d;
  logic [AXI_ID_WIDTH-1:0] id_q, id_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              len_q, len_d, beat_cnt_q, beat_cnt_d;
  logic [2:0]              size_q, size_d;
  logic [1:0]              burst_q, burst_d;
  logic                    err_q, err_d, wr_prio_q, wr_prio_d, ropc_q, ropc_d;
  logic [31:0]             wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]              strb_q, strb_d;

  logic [ADDR_WIDTH-1:0]   addr_inc, wrap_mask, addr_next;
  logic                    size_err, last_beat, sel_wr, sel_rd;
  logic                    unused_ok;

  // w_last is redundant with the latched length; the burst length alone counts beats
  assign unused_ok = w_last_i;

  // Next beat address for the latched burst type; reserved burst 11 steps like INCR
  always_comb begin
    addr_inc  = addr_q + ADDR_WIDTH'(4);
    wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << 2) - ADDR_WIDTH'(1);
    case (burst_q)
      2'b00:   addr_next = addr_q;
      2'b10:   addr_next = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
      default: addr_next = addr_inc;
    endcase
  end

  assign size_err     = (size_q != 3'b010) || (burst_q == 2'b11);
  assign last_beat    = (beat_cnt_q == len_q);
  assign sel_wr       = aw_valid_i && (!ar_valid_i || wr_prio_q);
  assign sel_rd       = ar_valid_i && !sel_wr;
  assign r_id_o       = id_q;
  assign b_id_o       = id_q;
  assign r_data_o     = rdata_q;
  assign data_addr_o  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign data_wdata_o = wdata_q;

  // Transaction sequencer: next state, latched fields and all handshake outputs
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    wr_prio_d  = wr_prio_q;
    ropc_d     = ropc_q;
    rdata_d    = rdata_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    aw_ready_o = 1'b0;
    ar_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    b_resp_o   = RESP_OKAY;
    r_valid_o  = 1'b0;
    r_resp_o   = RESP_OKAY;
    r_last_o   = 1'b0;
    data_req_o = 1'b0;
    data_we_o  = 1'b0;
    data_be_o  = 4'h0;
    case (state_q)
      IDLE: begin
        aw_ready_o = sel_wr;
        ar_ready_o = sel_rd;
        beat_cnt_d = 8'd0;
        err_d      = 1'b0;
        if (sel_wr) begin
          id_d = aw_id_i; addr_d = aw_addr_i; len_d = aw_len_i;
          size_d = aw_size_i; burst_d = aw_burst_i;
          wr_prio_d = 1'b0;
          state_d   = WR_DATA;
        end else if (sel_rd) begin
          id_d = ar_id_i; addr_d = ar_addr_i; len_d = ar_len_i;
          size_d = ar_size_i; burst_d = ar_burst_i;
          wr_prio_d = 1'b1;
          state_d   = RD_REQ;
        end
      end
      RD_REQ: begin
        data_req_o = 1'b1;
        data_be_o  = 4'hF;
        if (data_gnt_i) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (data_rvalid_i) begin
          rdata_d = data_rdata_i;
          ropc_d  = data_ropc_i;
          state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        r_valid_o = 1'b1;
        r_resp_o  = (ropc_q || size_err) ? RESP_SLVERR : RESP_OKAY;
        r_last_o  = last_beat;
        if (r_ready_i) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            addr_d     = addr_next;
            beat_cnt_d = beat_cnt_q + 8'd1;
            state_d    = RD_REQ;
          end
        end
      end
      WR_DATA: begin
        w_ready_o = 1'b1;
        if (w_valid_i) begin
          wdata_d = w_data_i;
          strb_d  = w_strb_i;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        data_req_o = 1'b1;
        data_we_o  = 1'b1;
        data_be_o  = strb_q;
        if (data_gnt_i) state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (data_rvalid_i) begin
          err_d = err_q | data_ropc_i;
          if (last_beat) begin
            state_d = WR_RESP;
          end else begin
            addr_d     = addr_next;
            beat_cnt_d = beat_cnt_q + 8'd1;
            state_d    = WR_DATA;
          end
        end
      end
      WR_RESP: begin
        b_valid_o = 1'b1;
        b_resp_o  = (err_q || size_err) ? RESP_SLVERR : RESP_OKAY;
        if (b_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; write side wins the first AW/AR tie after reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      wr_prio_q  <= 1'b1;
      ropc_q     <= 1'b0;
      rdata_q    <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      wr_prio_q  <= wr_prio_d;
      ropc_q     <= ropc_d;
      rdata_q    <= rdata_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
    end
  end

endmodule
